reu_dma_sequencer: RTL and testbench

//  Sequences REU block transfers between C64 memory and REU RAM. Requests the
//  C64 bus via DMA, drives address/data/R-W through the bus manager one byte per
//  bus cycle, and moves each byte through a req/ack port to REU RAM.

---
 rtl/reu_dma_sequencer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_reu_dma_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reu_dma_sequencer.sv
// reu_dma_sequencer: moves byte blocks between C64 memory and REU RAM.
// Takes the C64 bus by DMA, runs one C64 bus cycle per byte, and
// exchanges each byte with REU RAM over a req/ack port.
// Modes: stash (C64->REU), fetch (REU->C64), verify (compare, stop on mismatch).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, mode, c64_base,       transfer launch and configuration
//   reu_base, length,
//   fix_c64, fix_reu
//   cyc_start, cyc_end, ba, d_d  C64 bus cycle strobes, bus available, read data
//   dma, a_q, a_oe, rw_out,      C64 bus request and driven address/data/R-W
//   d_q, d_oe
//   ram_req, ram_we, ram_addr,   REU RAM request port
//   ram_wdata, ram_rdata, ram_ack
//   busy, done, verify_err       status
//   c64_cur, reu_cur, len_cur    live counters for register readback
module reu_dma_sequencer #(
   parameter int unsigned REU_AW = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [15:0]       c64_base,
   input  logic [REU_AW-1:0] reu_base,
   input  logic [15:0]       length,
   input  logic              fix_c64,
   input  logic              fix_reu,
   input  logic              cyc_start,
   input  logic              cyc_end,
   input  logic              ba,
   input  logic [7:0]        d_d,
   output logic              dma,
   output logic [15:0]       a_q,
   output logic              a_oe,
   output logic              rw_out,
   output logic [7:0]        d_q,
   output logic              d_oe,
   output logic              ram_req,
   output logic              ram_we,
   output logic [REU_AW-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   input  logic              ram_ack,
   output logic              busy,
   output logic              done,
   output logic              verify_err,
   output logic [15:0]       c64_cur,
   output logic [REU_AW-1:0] reu_cur,
   output logic [16:0]       len_cur
);

   localparam int unsigned LEN_W = 17;

   localparam logic [1:0] MODE_STASH  = 2'b00;
   localparam logic [1:0] MODE_FETCH  = 2'b01;
   localparam logic [1:0] MODE_RSVD   = 2'b10;
   localparam logic [1:0] MODE_VERIFY = 2'b11;

   // *_WAIT: waiting for a usable bus cycle; *_ACT: owning it until cyc_end
   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_WAIT,
      S_RD_ACT,
      S_WR_WAIT,
      S_WR_ACT,
      S_RAM_RD,
      S_RAM_WR,
      S_NEXT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic              fix_c64_q, fix_c64_d;
   logic              fix_reu_q, fix_reu_d;
   logic [7:0]        c64_byte_q, c64_byte_d;
   logic [7:0]        ram_byte_q, ram_byte_d;

   logic              dma_d, a_oe_d, rw_out_d, d_oe_d;
   logic [15:0]       a_q_d;
   logic [7:0]        d_q_d;
   logic              ram_req_d, ram_we_d;
   logic [REU_AW-1:0] ram_addr_d;
   logic [7:0]        ram_wdata_d;
   logic              busy_d, done_d, verify_err_d;
   logic [15:0]       c64_cur_d;
   logic [REU_AW-1:0] reu_cur_d;
   logic [LEN_W-1:0]  len_cur_d;

   logic              launch;
   logic [REU_AW-1:0] launch_addr;
   logic [15:0]       c64_inc;
   logic [REU_AW-1:0] reu_inc;

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      fix_c64_d    = fix_c64_q;
      fix_reu_d    = fix_reu_q;
      c64_byte_d   = c64_byte_q;
      ram_byte_d   = ram_byte_q;
      dma_d        = dma;
      a_q_d        = a_q;
      a_oe_d       = a_oe;
      rw_out_d     = rw_out;
      d_q_d        = d_q;
      d_oe_d       = d_oe;
      ram_req_d    = ram_req;
      ram_we_d     = ram_we;
      ram_addr_d   = ram_addr;
      ram_wdata_d  = ram_wdata;
      busy_d       = busy;
      done_d       = 1'b0;
      verify_err_d = verify_err;
      c64_cur_d    = c64_cur;
      reu_cur_d    = reu_cur;
      len_cur_d    = len_cur;
      launch       = 1'b0;
      launch_addr  = reu_cur;
      c64_inc      = fix_c64_q ? c64_cur : c64_cur + 16'd1;
      reu_inc      = fix_reu_q ? reu_cur : reu_cur + REU_AW'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d       = mode;
               fix_c64_d    = fix_c64;
               fix_reu_d    = fix_reu;
               c64_cur_d    = c64_base;
               reu_cur_d    = reu_base;
               len_cur_d    = (length == 16'd0) ? LEN_W'(17'h1_0000) : {1'b0, length};
               busy_d       = 1'b1;
               verify_err_d = 1'b0;
               if (mode == MODE_RSVD) begin
                  state_d = S_DONE;
               end else begin
                  dma_d       = 1'b1;
                  launch      = 1'b1;
                  launch_addr = reu_base;
               end
            end
         end
         S_RD_WAIT: begin
            if (cyc_start && ba) begin
               a_q_d    = c64_cur;
               a_oe_d   = 1'b1;
               rw_out_d = 1'b1;
               state_d  = S_RD_ACT;
            end
         end
         S_RD_ACT: begin
            if (cyc_end) begin
               a_oe_d     = 1'b0;
               c64_byte_d = d_d;
               if (mode_q == MODE_STASH) begin
                  ram_req_d   = 1'b1;
                  ram_we_d    = 1'b1;
                  ram_addr_d  = reu_cur;
                  ram_wdata_d = d_d;
                  state_d     = S_RAM_WR;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_WR_WAIT: begin
            if (cyc_start && ba) begin
               a_q_d    = c64_cur;
               d_q_d    = ram_byte_q;
               a_oe_d   = 1'b1;
               d_oe_d   = 1'b1;
               rw_out_d = 1'b0;
               state_d  = S_WR_ACT;
            end
         end
         S_WR_ACT: begin
            if (cyc_end) begin
               a_oe_d   = 1'b0;
               d_oe_d   = 1'b0;
               rw_out_d = 1'b1;
               state_d  = S_NEXT;
            end
         end
         S_RAM_WR: begin
            if (ram_ack) begin
               ram_req_d = 1'b0;
               state_d   = S_NEXT;
            end
         end
         S_RAM_RD: begin
            if (ram_ack) begin
               ram_req_d  = 1'b0;
               ram_byte_d = ram_rdata;
               state_d    = (mode_q == MODE_FETCH) ? S_WR_WAIT : S_RD_WAIT;
            end
         end
         S_NEXT: begin
            // Counters advance even for the byte that fails verification
            len_cur_d = len_cur - LEN_W'(1);
            c64_cur_d = c64_inc;
            reu_cur_d = reu_inc;
            if (mode_q == MODE_VERIFY && c64_byte_q != ram_byte_q) begin
               verify_err_d = 1'b1;
               state_d      = S_DONE;
            end else if (len_cur == LEN_W'(1)) begin
               state_d = S_DONE;
            end else begin
               launch      = 1'b1;
               launch_addr = reu_inc;
            end
         end
         S_DONE: begin
            dma_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // First step of a byte: stash starts on the C64 side, others at REU RAM
      if (launch) begin
         if (mode_d == MODE_STASH) begin
            state_d = S_RD_WAIT;
         end else begin
            ram_req_d  = 1'b1;
            ram_we_d   = 1'b0;
            ram_addr_d = launch_addr;
            state_d    = S_RAM_RD;
         end
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= MODE_STASH;
         fix_c64_q  <= 1'b0;
         fix_reu_q  <= 1'b0;
         c64_byte_q <= 8'd0;
         ram_byte_q <= 8'd0;
         dma        <= 1'b0;
         a_q        <= 16'd0;
         a_oe       <= 1'b0;
         rw_out     <= 1'b1;
         d_q        <= 8'd0;
         d_oe       <= 1'b0;
         ram_req    <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         verify_err <= 1'b0;
         c64_cur    <= 16'd0;
         reu_cur    <= '0;
         len_cur    <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         fix_c64_q  <= fix_c64_d;
         fix_reu_q  <= fix_reu_d;
         c64_byte_q <= c64_byte_d;
         ram_byte_q <= ram_byte_d;
         dma        <= dma_d;
         a_q        <= a_q_d;
         a_oe       <= a_oe_d;
         rw_out     <= rw_out_d;
         d_q        <= d_q_d;
         d_oe       <= d_oe_d;
         ram_req    <= ram_req_d;
         ram_we     <= ram_we_d;
         ram_addr   <= ram_addr_d;
         ram_wdata  <= ram_wdata_d;
         busy       <= busy_d;
         done       <= done_d;
         verify_err <= verify_err_d;
         c64_cur    <= c64_cur_d;
         reu_cur    <= reu_cur_d;
         len_cur    <= len_cur_d;
      end
   end

endmodule

// File: tb/tb_reu_dma_sequencer.sv
// tb_reu_dma_sequencer: self-checking bench for reu_dma_sequencer.
// A C64 bus model and an REU RAM model log every transaction; each transfer
// is predicted from C64/REU memory contents and the transfer rules, then the
// logs, counters and status flags are compared against that prediction.
module tb_reu_dma_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [15:0] c64_base;
   logic [23:0] reu_base;
   logic [15:0] length;
   logic        fix_c64, fix_reu;
   logic        cyc_start = 1'b0;
   logic        cyc_end = 1'b0;
   logic        ba = 1'b1;
   logic [7:0]  d_d = 8'd0;
   logic        dma, a_oe, rw_out, d_oe;
   logic [15:0] a_q;
   logic [7:0]  d_q;
   logic        ram_req, ram_we;
   logic [23:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'd0;
   logic        ram_ack = 1'b0;
   logic        busy, done, verify_err;
   logic [15:0] c64_cur;
   logic [23:0] reu_cur;
   logic [16:0] len_cur;

   reu_dma_sequencer #(.REU_AW(24)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .c64_base(c64_base), .reu_base(reu_base), .length(length),
      .fix_c64(fix_c64), .fix_reu(fix_reu),
      .cyc_start(cyc_start), .cyc_end(cyc_end), .ba(ba), .d_d(d_d),
      .dma(dma), .a_q(a_q), .a_oe(a_oe), .rw_out(rw_out), .d_q(d_q), .d_oe(d_oe),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
      .busy(busy), .done(done), .verify_err(verify_err),
      .c64_cur(c64_cur), .reu_cur(reu_cur), .len_cur(len_cur)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Environment state
   logic [7:0]  c64_mem [0:65535];
   logic [7:0]  ram_mem [logic [23:0]];
   logic [31:0] ram_wr_q[$];   // {addr, data}
   logic [23:0] ram_rd_q[$];   // addr
   logic [15:0] c64_rd_q[$];   // addr
   logic [23:0] c64_wr_q[$];   // {addr, data}
   int phase = 3;
   int stall_left = 0;
   bit rand_ba = 1'b0;
   bit rand_ack = 1'b0;
   int ack_dly = 1;
   bit dma_expect = 1'b1;
   int bus_viol = 0;
   int ram_viol = 0;
   int dma_viol = 0;
   int done_cnt = 0;

   function automatic logic [7:0] ram_val(input logic [23:0] a);
      if (ram_mem.exists(a)) return ram_mem[a];
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // C64 bus: cycle strobes every 4 clocks, ba per cycle, memory and monitor
   always @(negedge clk) begin
      phase = (phase + 1) % 4;
      cyc_start = (phase == 0);
      cyc_end   = (phase == 2);
      if (phase == 0) begin
         if (stall_left > 0) begin
            ba = 1'b0;
            stall_left--;
         end else if (rand_ba) ba = ($urandom_range(0, 3) != 0);
         else ba = 1'b1;
      end
      if (a_oe && !ba) bus_viol++;
      if (a_oe && !busy) bus_viol++;
      if (d_oe && (rw_out || !a_oe)) bus_viol++;
      if (!a_oe && !rw_out) bus_viol++;
      d_d = (a_oe && rw_out) ? c64_mem[a_q] : 8'($urandom);
      if (cyc_end && a_oe) begin
         if (rw_out) c64_rd_q.push_back(a_q);
         else begin
            c64_wr_q.push_back({a_q, d_q});
            c64_mem[a_q] = d_q;
         end
      end
      if (busy && !dma && dma_expect) dma_viol++;
      if (!dma_expect && dma) dma_viol++;
      if (done) done_cnt++;
   end

   // REU RAM: acknowledges after a delay, checks request stability
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [23:0] pa;
   logic        pw;
   logic [7:0]  pd;
   always @(negedge clk) begin
      ram_ack = 1'b0;
      ram_rdata = 8'($urandom);
      if (ram_req) begin
         if (!pend) begin
            pend = 1'b1;
            cnt = rand_ack ? $urandom_range(0, 3) : ack_dly;
            pa = ram_addr;
            pw = ram_we;
            pd = ram_wdata;
         end else if (ram_addr !== pa || ram_we !== pw || (pw && ram_wdata !== pd)) begin
            ram_viol++;
         end
         if (cnt == 0) begin
            ram_ack = 1'b1;
            pend = 1'b0;
            if (pw) begin
               ram_mem[pa] = pd;
               ram_wr_q.push_back({pa, pd});
            end else begin
               ram_rdata = ram_val(pa);
               ram_rd_q.push_back(pa);
            end
         end else cnt--;
      end else pend = 1'b0;
   end

   task automatic clear_logs();
      ram_wr_q.delete();
      ram_rd_q.delete();
      c64_rd_q.delete();
      c64_wr_q.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [15:0] cb, input logic [23:0] rb,
                              input logic [15:0] ln, input logic fc, input logic fr);
      @(negedge clk);
      start = 1'b1; mode = m; c64_base = cb; reu_base = rb; length = ln;
      fix_c64 = fc; fix_reu = fr;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Predict a transfer, run it, and compare everything observable
   task automatic run_and_check(input string tag, input logic [1:0] m, input logic [15:0] cb,
                                input logic [23:0] rb, input logic [15:0] ln,
                                input logic fc, input logic fr, input bit poke_busy);
      int n, processed;
      logic mism;
      logic [15:0] c;
      logic [23:0] r;
      logic [31:0] e_rw[$];
      logic [23:0] e_rr[$];
      logic [15:0] e_cr[$];
      logic [23:0] e_cw[$];
      bit got;
      n = (ln == 16'd0) ? 65536 : int'(ln);
      processed = n;
      mism = 1'b0;
      for (int i = 0; i < n; i++) begin
         c = fc ? cb : 16'(cb + 16'(i));
         r = fr ? rb : 24'(rb + 24'(i));
         if (m == 2'b00) begin
            e_cr.push_back(c);
            e_rw.push_back({r, c64_mem[c]});
         end else if (m == 2'b01) begin
            e_rr.push_back(r);
            e_cw.push_back({c, ram_val(r)});
         end else begin
            e_rr.push_back(r);
            e_cr.push_back(c);
            if (c64_mem[c] != ram_val(r)) begin
               mism = 1'b1;
               processed = i + 1;
               break;
            end
         end
      end
      clear_logs();
      pulse_start(m, cb, rb, ln, fc, fr);
      chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
      chk({tag, "_verr_cleared"}, 32'(verify_err), 32'd0);
      if (poke_busy) begin
         repeat (2) @(negedge clk);
         start = 1'b1; mode = 2'b01; c64_base = 16'h5555; reu_base = 24'h777777;
         length = 16'd9; fix_c64 = 1'b1; fix_reu = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 5000 && !got; i++) begin
         if (done) got = 1'b1;
         else @(negedge clk);
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      repeat (2) @(negedge clk);
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_dma_end"}, 32'(dma), 32'd0);
      chk({tag, "_verr"}, 32'(verify_err), 32'(mism));
      chk({tag, "_len_cur"}, 32'(len_cur), 32'(n - processed));
      chk({tag, "_c64_cur"}, 32'(c64_cur), 32'(fc ? cb : 16'(cb + 16'(processed))));
      chk({tag, "_reu_cur"}, 32'(reu_cur), 32'(fr ? rb : 24'(rb + 24'(processed))));
      chk({tag, "_n_ramwr"}, 32'(ram_wr_q.size()), 32'(e_rw.size()));
      chk({tag, "_n_ramrd"}, 32'(ram_rd_q.size()), 32'(e_rr.size()));
      chk({tag, "_n_c64rd"}, 32'(c64_rd_q.size()), 32'(e_cr.size()));
      chk({tag, "_n_c64wr"}, 32'(c64_wr_q.size()), 32'(e_cw.size()));
      if (ram_wr_q.size() == e_rw.size())
         foreach (e_rw[i]) chk($sformatf("%s_ramwr%0d", tag, i), ram_wr_q[i], e_rw[i]);
      if (ram_rd_q.size() == e_rr.size())
         foreach (e_rr[i]) chk($sformatf("%s_ramrd%0d", tag, i), 32'(ram_rd_q[i]), 32'(e_rr[i]));
      if (c64_rd_q.size() == e_cr.size())
         foreach (e_cr[i]) chk($sformatf("%s_c64rd%0d", tag, i), 32'(c64_rd_q[i]), 32'(e_cr[i]));
      if (c64_wr_q.size() == e_cw.size())
         foreach (e_cw[i]) chk($sformatf("%s_c64wr%0d", tag, i), 32'(c64_wr_q[i]), 32'(e_cw[i]));
      chk({tag, "_bus_viol"}, 32'(bus_viol), 32'd0);
      chk({tag, "_ram_viol"}, 32'(ram_viol), 32'd0);
      chk({tag, "_dma_viol"}, 32'(dma_viol), 32'd0);
   endtask

   initial begin : stim
      logic [1:0]  m;
      logic [15:0] cb, c;
      logic [23:0] rb, r;
      logic [15:0] ln;
      logic        fc, fr;
      int          mm, nw, bad;
      bit          got;

      rst = 1'b1; start = 1'b0; mode = 2'b00; c64_base = 16'd0; reu_base = 24'd0;
      length = 16'd0; fix_c64 = 1'b0; fix_reu = 1'b0;
      for (int i = 0; i < 65536; i++) c64_mem[i] = 8'($urandom);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dma", 32'(dma), 32'd0);
      chk("rst_a_oe", 32'(a_oe), 32'd0);
      chk("rst_d_oe", 32'(d_oe), 32'd0);
      chk("rst_rw", 32'(rw_out), 32'd1);
      chk("rst_ram_req", 32'(ram_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_verr", 32'(verify_err), 32'd0);
      chk("rst_len_cur", 32'(len_cur), 32'd0);

      // Stash three bytes, fixed 2-clock RAM acknowledge
      run_and_check("stash3", 2'b00, 16'hC000, 24'h000100, 16'd3, 1'b0, 1'b0, 1'b0);
      chk("stash3_reu_end", 32'(reu_cur), 32'h103);

      // Fetch with three unusable bus cycles in the middle of the first byte
      clear_logs();
      fork
         run_and_check("fetch_stall", 2'b01, 16'h1234, 24'h000200, 16'd2, 1'b0, 1'b0, 1'b0);
         begin
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
               @(negedge clk);
               if (ram_req) got = 1'b1;
            end
            stall_left = 3;
         end
      join
      chk("fetch_stall_armed", 32'(got), 32'd1);

      // Address wrap on both sides
      run_and_check("wrap", 2'b00, 16'hFFFF, 24'hFFFFFF, 16'd2, 1'b0, 1'b0, 1'b0);
      if (ram_wr_q.size() == 2) chk("wrap_reu_second", 32'(ram_wr_q[1][31:8]), 32'h0);
      if (c64_rd_q.size() == 2) chk("wrap_c64_second", 32'(c64_rd_q[1]), 32'h0);

      // Verify with a mismatch at the third byte, then a clean verify
      for (int i = 0; i < 4; i++) c64_mem[16'h2000 + i] = ram_val(24'h000300 + 24'(i));
      c64_mem[16'h2002] = ram_val(24'h000302) ^ 8'h01;
      run_and_check("verify_mm", 2'b11, 16'h2000, 24'h000300, 16'd4, 1'b0, 1'b0, 1'b0);
      chk("verify_mm_len1", 32'(len_cur), 32'd1);
      chk("verify_mm_err", 32'(verify_err), 32'd1);
      run_and_check("verify_ok", 2'b11, 16'h2000, 24'h000300, 16'd2, 1'b0, 1'b0, 1'b0);

      // Start while busy must not disturb the running transfer
      run_and_check("busy_start", 2'b00, 16'h4000, 24'h000010, 16'd2, 1'b0, 1'b0, 1'b1);

      // Randomized transfers
      rand_ba = 1'b1;
      rand_ack = 1'b1;
      for (int t = 0; t < 10; t++) begin
         case ($urandom_range(0, 2))
            0: m = 2'b00;
            1: m = 2'b01;
            default: m = 2'b11;
         endcase
         cb = 16'($urandom);
         rb = 24'($urandom);
         ln = 16'($urandom_range(1, 6));
         fc = 1'($urandom_range(0, 1));
         fr = 1'($urandom_range(0, 1));
         if (m == 2'b11) begin
            mm = $urandom_range(0, int'(ln));
            for (int i = 0; i < int'(ln); i++) begin
               c = fc ? cb : 16'(cb + 16'(i));
               r = fr ? rb : 24'(rb + 24'(i));
               c64_mem[c] = (i == mm) ? (ram_val(r) ^ 8'h80) : ram_val(r);
            end
         end
         run_and_check($sformatf("rnd%0d", t), m, cb, rb, ln, fc, fr, 1'b0);
      end
      rand_ba = 1'b0;
      rand_ack = 1'b0;

      // length 0 = 65536 with both addresses fixed; aborted by reset mid-request
      clear_logs();
      pulse_start(2'b01, 16'h3333, 24'h00ABCD, 16'd0, 1'b1, 1'b1);
      chk("len0_len_cur", 32'(len_cur), 32'h10000);
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk);
         if (c64_wr_q.size() >= 30) got = 1'b1;
      end
      chk("len0_progress", 32'(got), 32'd1);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (ram_req && !ram_ack) got = 1'b1;
      end
      chk("len0_req_seen", 32'(got), 32'd1);
      nw = c64_wr_q.size();
      chk("len0_len_track", 32'(len_cur), 32'(65536 - nw));
      chk("len0_c64_fixed", 32'(c64_cur), 32'h3333);
      bad = 0;
      foreach (c64_wr_q[i]) if (c64_wr_q[i] != {16'h3333, ram_val(24'h00ABCD)}) bad++;
      foreach (ram_rd_q[i]) if (ram_rd_q[i] != 24'h00ABCD) bad++;
      chk("len0_fixed_addrs", 32'(bad), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ram_req", 32'(ram_req), 32'd0);
      chk("abort_dma", 32'(dma), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_a_oe", 32'(a_oe), 32'd0);
      chk("abort_len_cur", 32'(len_cur), 32'd0);
      repeat (4) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'd0);

      // Reserved mode: done one clock after start, no bus or RAM activity
      clear_logs();
      dma_expect = 1'b0;
      pulse_start(2'b10, 16'h1111, 24'h222222, 16'd5, 1'b0, 1'b0);
      chk("rsvd_busy", 32'(busy), 32'd1);
      chk("rsvd_done_early", 32'(done), 32'd0);
      @(negedge clk);
      chk("rsvd_done", 32'(done), 32'd1);
      @(negedge clk);
      chk("rsvd_done_once", 32'(done), 32'd0);
      chk("rsvd_busy_end", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("rsvd_activity", 32'(ram_wr_q.size() + ram_rd_q.size() + c64_rd_q.size() + c64_wr_q.size()), 32'd0);
      chk("rsvd_dma_viol", 32'(dma_viol), 32'd0);
      dma_expect = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
